// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the parametrised UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Ceiling log2 with a floor of one bit so counters are never zero-width.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Two-flop rx synchroniser plus sample-point bit source.
// UART_RX_MAJORITY_EN selects a 2-of-3 vote over the last three s_tick samples.
module uart_bit_sampler (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_i,
    input  logic s_tick_i,
    output logic rx_s_o,
    output logic smp_o
);

    logic sync1_q;
    logic sync2_q;

    // Flops reset high so an idle line is never mistaken for a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s_o = sync2_q;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    // Ticks are contiguous within a bit, so the two previous captures are s-2 and s-1.
    always_ff @(posedge clk) begin
        if (s_tick_i) hist_q <= {hist_q[0], sync2_q};
    end

    assign smp_o = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync2_q) | (hist_q[0] & sync2_q);
`else
    logic unused_tick;
    assign unused_tick = s_tick_i;
    assign smp_o       = sync2_q;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with parity, framing error and break lockout.
// Build option UART_RX_MAJORITY_EN enables 3-sample majority voting in the sampler.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int OVS     = 16,
    parameter int SB_BITS = 1,
    parameter int PARITY  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            parity_err,
    output logic            frame_err,
    output logic            busy
);

    localparam int SW = clog2(OVS);
    localparam int NW = clog2(DBIT);
    localparam logic [SW-1:0] S_MID   = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_LAST  = SW'(OVS - 1);
    localparam logic [SW-1:0] S_ONE   = SW'(1);
    localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);
    localparam logic [NW-1:0] SB_LAST = NW'(SB_BITS - 1);
    localparam logic [NW-1:0] N_ONE   = NW'(1);

    logic rx_s;
    logic smp;

    uart_bit_sampler u_smp (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_i     (rx),
        .s_tick_i (s_tick),
        .rx_s_o   (rx_s),
        .smp_o    (smp)
    );

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            armed_q, armed_d;
    logic            done_q, done_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic            perr_pend_q, perr_pend_d;
    logic            ferr_pend_q, ferr_pend_d;
    logic            ferr_now;
    logic            clear_arm;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            n_q         <= '0;
            b_q         <= '0;
            dout_q      <= '0;
            armed_q     <= 1'b0;
            done_q      <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            perr_pend_q <= 1'b0;
            ferr_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            b_q         <= b_d;
            dout_q      <= dout_d;
            armed_q     <= armed_d;
            done_q      <= done_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            perr_pend_q <= perr_pend_d;
            ferr_pend_q <= ferr_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        b_d         = b_q;
        dout_d      = dout_q;
        done_d      = 1'b0;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        perr_pend_d = perr_pend_q;
        ferr_pend_d = ferr_pend_q;
        ferr_now    = ferr_pend_q | ~smp;
        clear_arm   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (armed_q && !rx_s) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        s_d = '0;
                        if (!smp) begin
                            state_d     = ST_DATA;
                            n_d         = '0;
                            perr_pend_d = 1'b0;
                            ferr_pend_d = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        b_d = {smp, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            n_d     = '0;
                            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            n_d = n_q + N_ONE;
                        end
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        perr_pend_d = (^b_q) ^ smp ^ (PARITY == PAR_ODD);
                        state_d     = ST_STOP;
                        s_d         = '0;
                        n_d         = '0;
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        if (n_q == SB_LAST) begin
                            state_d   = ST_IDLE;
                            n_d       = '0;
                            dout_d    = b_q;
                            perr_d    = (PARITY != PAR_NONE) && perr_pend_q;
                            ferr_d    = ferr_now;
                            done_d    = 1'b1;
                            clear_arm = ferr_now;
                        end else begin
                            n_d         = n_q + N_ONE;
                            ferr_pend_d = ferr_now;
                        end
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A high line always re-arms; a framing error disarms so a held break cannot retrigger.
        armed_d = rx_s | (armed_q & ~clear_arm);
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign parity_err   = perr_q;
    assign frame_err    = ferr_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: 8N1, 8E1 and 7O2 instances driven by directed frames.
module tb_uart_rx_param;

    localparam int BT = 32;  // clk per bit: 16 ticks, one tick every 2 clk

    typedef struct packed {
        logic [8:0] d;
        logic       p;
        logic       f;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic s_tick;
    logic rx0, rx1, rx2;
    logic [7:0] dout0, dout1;
    logic [6:0] dout2;
    logic done0, done1, done2;
    logic perr0, perr1, perr2;
    logic ferr0, ferr1, ferr2;
    logic busy0, busy1, busy2;

    exp_t q0[$], q1[$], q2[$];
    int passed = 0;
    int total  = 0;
    logic pd0 = 1'b0, pd1 = 1'b0, pd2 = 1'b0;

    always #5 clk = ~clk;

    uart_rx_param #(.DBIT(8), .OVS(16), .SB_BITS(1), .PARITY(0)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .s_tick(s_tick), .dout(dout0),
        .rx_done_tick(done0), .parity_err(perr0), .frame_err(ferr0), .busy(busy0));

    uart_rx_param #(.DBIT(8), .OVS(16), .SB_BITS(1), .PARITY(1)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .s_tick(s_tick), .dout(dout1),
        .rx_done_tick(done1), .parity_err(perr1), .frame_err(ferr1), .busy(busy1));

    uart_rx_param #(.DBIT(7), .OVS(16), .SB_BITS(2), .PARITY(2)) u_7o2 (
        .clk(clk), .rst_n(rst_n), .rx(rx2), .s_tick(s_tick), .dout(dout2),
        .rx_done_tick(done2), .parity_err(perr2), .frame_err(ferr2), .busy(busy2));

    task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic mon(input int idx, input logic [8:0] d, input logic p, input logic f,
                       input logic b);
        exp_t e;
        int   sz;
        sz = (idx == 0) ? q0.size() : (idx == 1) ? q1.size() : q2.size();
        if (sz == 0) begin
            total++;
            $display("FAIL unexpected_pulse[%0d]: got dout 0x%0h expected no pulse", idx, d);
        end else begin
            case (idx)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            check($sformatf("dout[%0d]", idx), d, e.d);
            check($sformatf("parity_err[%0d]", idx), {8'd0, p}, {8'd0, e.p});
            check($sformatf("frame_err[%0d]", idx), {8'd0, f}, {8'd0, e.f});
            check($sformatf("busy_at_done[%0d]", idx), {8'd0, b}, 9'd0);
        end
    endtask

    // Monitor: checks pulses against the scoreboard and that each pulse lasts one clk.
    always @(negedge clk) begin
        if (pd0) check("pulse_width[0]", {8'd0, done0}, 9'd0);
        if (pd1) check("pulse_width[1]", {8'd0, done1}, 9'd0);
        if (pd2) check("pulse_width[2]", {8'd0, done2}, 9'd0);
        if (done0) mon(0, {1'b0, dout0}, perr0, ferr0, busy0);
        if (done1) mon(1, {1'b0, dout1}, perr1, ferr1, busy1);
        if (done2) mon(2, {2'b0, dout2}, perr2, ferr2, busy2);
        pd0 = done0;
        pd1 = done1;
        pd2 = done2;
    end

    initial begin
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            s_tick = ~s_tick;
        end
    end

    task automatic bitx(input int idx, input logic v, input int ncl);
        case (idx)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
        repeat (ncl) @(negedge clk);
    endtask

    task automatic send(input int idx, input int nd, input logic [8:0] data, input bit haspar,
                        input logic pbit, input int nstop, input logic [1:0] stops);
        bitx(idx, 1'b0, BT);
        for (int i = 0; i < nd; i++) bitx(idx, data[i], BT);
        if (haspar) bitx(idx, pbit, BT);
        for (int i = 0; i < nstop; i++) bitx(idx, stops[i], BT);
        bitx(idx, 1'b1, BT);
    endtask

    initial begin
        rst_n = 1'b0;
        rx0 = 1'b1;
        rx1 = 1'b1;
        rx2 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dout0", {1'b0, dout0}, 9'd0);
        check("rst_done0", {8'd0, done0}, 9'd0);
        check("rst_busy0", {8'd0, busy0}, 9'd0);
        check("rst_perr1", {8'd0, perr1}, 9'd0);
        check("rst_ferr2", {8'd0, ferr2}, 9'd0);
        rst_n = 1'b1;
        repeat (4 * BT) @(negedge clk);

        // 8N1 basic frame
        q0.push_back('{d: 9'h0A5, p: 1'b0, f: 1'b0});
        send(0, 8, 9'h0A5, 1'b0, 1'b0, 1, 2'b11);

        // 8E1: wrong then correct parity for 0x3C (four ones -> even parity bit 0)
        q1.push_back('{d: 9'h03C, p: 1'b1, f: 1'b0});
        send(1, 8, 9'h03C, 1'b1, 1'b1, 1, 2'b11);
        q1.push_back('{d: 9'h03C, p: 1'b0, f: 1'b0});
        send(1, 8, 9'h03C, 1'b1, 1'b0, 1, 2'b11);

        // 7O2: 0x55 has four ones -> odd parity bit 1; second stop low, then a clean frame
        q2.push_back('{d: 9'h055, p: 1'b0, f: 1'b1});
        send(2, 7, 9'h055, 1'b1, 1'b1, 2, 2'b01);
        q2.push_back('{d: 9'h055, p: 1'b0, f: 1'b0});
        send(2, 7, 9'h055, 1'b1, 1'b1, 2, 2'b11);

        // Short glitch: three ticks low, shorter than half a bit
        bitx(0, 1'b0, 4);
        check("glitch_busy_high", {8'd0, busy0}, 9'd1);
        bitx(0, 1'b0, 2);
        bitx(0, 1'b1, 2 * BT);
        check("glitch_busy_low", {8'd0, busy0}, 9'd0);

        // Break for three frame times, then recovery with 0x81
        q0.push_back('{d: 9'h000, p: 1'b0, f: 1'b1});
        bitx(0, 1'b0, 30 * BT);
        bitx(0, 1'b1, 2 * BT);
        check("break_idle_busy", {8'd0, busy0}, 9'd0);
        q0.push_back('{d: 9'h081, p: 1'b0, f: 1'b0});
        send(0, 8, 9'h081, 1'b0, 1'b0, 1, 2'b11);

        // Reset during data bit 4 of 0xFF
        bitx(0, 1'b0, BT);
        bitx(0, 1'b1, 4 * BT + BT / 2);
        check("mid_frame_busy", {8'd0, busy0}, 9'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_dout0", {1'b0, dout0}, 9'd0);
        check("mid_rst_busy0", {8'd0, busy0}, 9'd0);
        rst_n = 1'b1;
        bitx(0, 1'b1, 6 * BT);
        q0.push_back('{d: 9'h012, p: 1'b0, f: 1'b0});
        send(0, 8, 9'h012, 1'b0, 1'b0, 1, 2'b11);

        repeat (2 * BT) @(negedge clk);
        check("q0_drained", 9'(q0.size()), 9'd0);
        check("q1_drained", 9'(q1.size()), 9'd0);
        check("q2_drained", 9'(q2.size()), 9'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
